// File: rtl/shift_assembler.sv
// Reassembles a 1-bit or 8-bit shifted-out stream into a parallel word.
// The closed word is offered on a valid/ready port.
module shift_assembler #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic             in_dir,
    input  logic [7:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [6:0]       out_bits,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {FILL, FULL} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ovf_q, ovf_d;

    logic             beat;
    logic [CW-1:0]    room;
    logic [3:0]       k;
    logic [CW-1:0]    sum;
    logic [7:0]       payload;
    logic [WIDTH-1:0] wide;
    logic [CW-1:0]    topShift;

    // Beat geometry: k bits enter the word, taken from the byte end that leaves the shifter first.
    always_comb begin
        room = CW'(WIDTH) - count_q;
        k    = 4'd1;
        if (in_mode) begin
            k = (room < CW'(8)) ? room[3:0] : 4'd8;
        end
        beat = in_valid && (state_q == FILL);
        if (in_dir) begin
            payload = in_data & 8'((9'd1 << k) - 9'd1);
        end else if (in_mode) begin
            payload = in_data >> (4'd8 - k);
        end else begin
            payload = {7'd0, in_data[0]};
        end
        wide     = {{(WIDTH-8){1'b0}}, payload};
        topShift = CW'(WIDTH) - CW'(k);
        sum      = count_q + (beat ? CW'(k) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            count_q <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
        case (state_q)
            FILL: begin
                if (beat) begin
                    word_d  = in_dir ? ((word_q >> k) | (wide << topShift))
                                     : ((word_q << k) | wide);
                    count_d = sum;
                    if (in_mode && (k != 4'd8)) begin
                        ovf_d = 1'b1;
                    end
                end
                // A beat arriving with flush lands first; an empty flush is ignored.
                if ((sum == CW'(WIDTH)) || (flush && (sum != '0))) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = FILL;
                    count_d = '0;
                    word_d  = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == FULL);
        out_data  = word_q;
        out_bits  = 7'(count_q);
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_shift_assembler.sv
// Directed and random stimulus for shift_assembler, checked against a
// bit-serial reference model of the reassembly rules.
module tb_shift_assembler;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, in_mode, in_dir, flush;
    logic         out_valid, out_ready, overflow;
    logic [7:0]   in_data;
    logic [W-1:0] out_data;
    logic [6:0]   out_bits;

    int checks = 0;
    int errors = 0;

    logic         mFull;
    int           mCount;
    logic [W-1:0] mWord;
    logic         mOvf;

    always #5 clk = ~clk;

    shift_assembler #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_dir(in_dir), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bits(out_bits), .overflow(overflow)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: every received bit is pushed into the word one at a time, in stream order.
    task automatic modelStep(input logic rst, input logic v, input logic mode, input logic dir,
                             input logic [7:0] data, input logic fl, input logic ordy);
        int   k;
        logic b;
        if (rst) begin
            mFull = 0; mCount = 0; mWord = '0; mOvf = 0;
        end else if (mFull) begin
            if (ordy) begin
                mFull = 0; mCount = 0; mWord = '0;
            end
        end else begin
            if (v) begin
                k = mode ? ((W - mCount) < 8 ? (W - mCount) : 8) : 1;
                if (mode && k < 8) mOvf = 1;
                for (int i = 0; i < k; i++) begin
                    if (!mode)     b = data[0];
                    else if (!dir) b = data[7-i];
                    else           b = data[i];
                    mWord = dir ? {b, mWord[W-1:1]} : {mWord[W-2:0], b};
                end
                mCount += k;
            end
            if (mCount == W || (fl && mCount > 0)) mFull = 1;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic mode, input logic dir,
                                 input logic [7:0] data, input logic fl, input logic ordy);
        reset = rst; in_valid = v; in_mode = mode; in_dir = dir;
        in_data = data; flush = fl; out_ready = ordy;
        modelStep(rst, v, mode, dir, data, fl, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " in_ready"}, 64'(in_ready), 64'(!mFull));
        checkVal({tag, " out_valid"}, 64'(out_valid), 64'(mFull));
        checkVal({tag, " overflow"}, 64'(overflow), 64'(mOvf));
        if (mFull) begin
            checkVal({tag, " out_data"}, out_data, mWord);
            checkVal({tag, " out_bits"}, 64'(out_bits), 64'(mCount));
        end
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, ordy);
    endtask

    initial begin
        logic [7:0] bytes3 [3];
        bytes3[0] = 8'hDE; bytes3[1] = 8'hAD; bytes3[2] = 8'hBE;

        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0);
        checkOutput("reset");
        checkVal("reset out_data", out_data, 64'h0);
        checkVal("reset out_bits", 64'(out_bits), 64'h0);

        // Empty flush must not close a word
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 1);
        checkOutput("empty_flush");

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1, 1, 0, 8'(i), 0, 1);
            checkOutput("left_bytes");
        end
        checkVal("left_bytes const", out_data, 64'h0102030405060708);
        checkVal("left_bytes bits", 64'(out_bits), 64'd64);
        idle(1);
        checkOutput("left_bytes handoff");

        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1, 1, 1, 8'(i), 0, 1);
            checkOutput("right_bytes");
        end
        checkVal("right_bytes const", out_data, 64'h0807060504030201);
        idle(1);

        for (int i = 0; i < W; i++) applyStimulus(0, 1, 0, 0, 8'((i % 2) == 0), 0, 0);
        checkOutput("left_bits");
        checkVal("left_bits const", out_data, 64'hAAAAAAAAAAAAAAAA);
        idle(1);
        for (int i = 0; i < W; i++) applyStimulus(0, 1, 0, 1, 8'((i % 2) == 0), 0, 0);
        checkOutput("right_bits");
        checkVal("right_bits const", out_data, 64'h5555555555555555);
        idle(1);

        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, bytes3[i], i == 2, 0);
        checkOutput("left_flush");
        checkVal("left_flush const", out_data, 64'h0000000000DEADBE);
        checkVal("left_flush bits", 64'(out_bits), 64'd24);
        applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);
        checkOutput("flush_while_full");
        idle(1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, bytes3[i], i == 2, 0);
        checkOutput("right_flush");
        checkVal("right_flush const", out_data, 64'hBEADDE0000000000);
        idle(1);

        for (int i = 0; i < 60; i++) applyStimulus(0, 1, 0, 0, 8'h01, 0, 0);
        applyStimulus(0, 1, 1, 0, 8'h5A, 0, 0);
        checkOutput("truncate");
        checkVal("truncate const", out_data, 64'hFFFFFFFFFFFFFFF5);
        checkVal("truncate ovf", 64'(overflow), 64'h1);
        idle(1);
        applyStimulus(0, 1, 1, 0, 8'h33, 0, 0);
        applyStimulus(0, 1, 1, 0, 8'h44, 1, 0);
        checkOutput("ovf_sticky");
        checkVal("ovf_sticky const", 64'(overflow), 64'h1);
        idle(1);

        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 0, 8'hFF, 0, 0);
            checkOutput("backpressure");
            checkVal("backpressure const", out_data, 64'hA0A1A2A3A4A5A6A7);
        end
        idle(1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 8'h77, 0, 0);
        applyStimulus(1, 1, 1, 0, 8'h77, 1, 0);
        checkOutput("mid_reset");
        checkVal("mid_reset out_data", out_data, 64'h0);
        checkVal("mid_reset out_bits", 64'(out_bits), 64'h0);
        applyStimulus(0, 1, 1, 0, 8'h11, 1, 0);
        checkOutput("fresh");
        checkVal("fresh const", out_data, 64'h11);
        checkVal("fresh bits", 64'(out_bits), 64'd8);
        idle(1);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                          1'($urandom), 1'($urandom), 8'($urandom),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
            checkOutput("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
